// File: rtl/mult4_seq_ctrl.sv
// Control FSM for the shift-and-add multiplier: sequences load, conditional add
// and shift strobes per multiplier bit, with a start/done handshake.
module mult4_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          q0,
    output logic          load,
    output logic          add_en,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Encodings 6 and 7 fall through to IDLE so a corrupted state self-recovers.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_TEST;
            S_TEST:  state_nxt = q0 ? S_ADD : S_SHIFT;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = (cnt == LAST_ITER) ? S_DONE : S_TEST;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt keeps its final value after DONE until the next LOAD clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (state == S_SHIFT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign load   = (state == S_LOAD);
    assign add_en = (state == S_ADD);
    assign shift  = (state == S_SHIFT);
    assign done   = (state == S_DONE);
    assign busy   = (state == S_LOAD) || (state == S_TEST) ||
                    (state == S_ADD)  || (state == S_SHIFT);

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed bench for mult4_seq_ctrl: drives the FSM against a small bench-side
// accumulator/multiplier datapath and checks strobes, latency and products.
module tb_mult4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       q0;
    logic       load, add_en, shift, busy, done;
    logic [2:0] cnt;

    logic [4:0] acc = '0;
    logic [3:0] qr = '0;
    logic [3:0] mr = '0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;

    int checks = 0;
    int passed = 0;

    mult4_seq_ctrl #(.N(4), .CW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .q0     (q0),
        .load   (load),
        .add_en (add_en),
        .shift  (shift),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    // Datapath the FSM controls: 5-bit accumulator keeps the add carry in bit 4.
    always @(posedge clk) begin
        if (load) begin
            acc <= '0;
            mr  <= a_in;
            qr  <= b_in;
        end else if (add_en) begin
            acc <= acc + {1'b0, mr};
        end else if (shift) begin
            {acc, qr} <= {1'b0, acc, qr[3:1]};
        end
    end

    assign q0 = qr[0];

    task automatic applyStimulus(input logic start_v);
        start = start_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic runOp(input logic [3:0] mc, input logic [3:0] mp, input int exp_done,
                         input logic [3:0] exp_mask, input logic [7:0] exp_prod,
                         input bit start_in_done);
        int         cyc;
        int         donecyc;
        int         loads;
        int         viol;
        logic [3:0] mask;
        a_in = mc;
        b_in = mp;
        applyStimulus(1'b1);
        cyc = 1; donecyc = 0; loads = 0; viol = 0; mask = '0;
        while (cyc <= 40 && donecyc == 0) begin
            if (load) loads++;
            if (add_en && cnt < 3'd4) mask[cnt[1:0]] = 1'b1;
            if ((int'(load) + int'(add_en) + int'(shift)) > 1 || (done && busy)) viol++;
            if (cyc == 1) checkOutput("load_first_cycle", {load, busy}, 2'b11);
            if (cyc == 2) checkOutput("cnt_cleared", cnt, 3'd0);
            if (done) donecyc = cyc;
            else begin
                applyStimulus(cyc == 5);
                cyc++;
            end
        end
        checkOutput("done_latency", donecyc, exp_done);
        checkOutput("single_load", loads, 1);
        checkOutput("add_mask", mask, exp_mask);
        checkOutput("strobe_exclusive", viol, 0);
        checkOutput("done_cnt", cnt, 3'd4);
        checkOutput("done_not_busy", busy, 1'b0);
        checkOutput("product", {acc[3:0], qr}, exp_prod);
        checkOutput("acc_msb_clear", acc[4], 1'b0);
        applyStimulus(start_in_done);
        checkOutput("idle_after_done", {load, add_en, shift, busy, done}, 5'b0);
        checkOutput("idle_cnt_hold", cnt, 3'd4);
        applyStimulus(1'b0);
        checkOutput("still_idle", {load, busy}, 2'b00);
    endtask

    initial begin
        logic lg_load [1:30];
        logic lg_busy [1:30];
        logic lg_done [1:30];
        int   ndone;
        int   k;

        $display("[TB] reset and idle");
        #1;
        checkOutput("reset_outputs", {load, add_en, shift, busy, done}, 5'b0);
        checkOutput("reset_cnt", cnt, 3'd0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            checkOutput("idle_outputs", {load, add_en, shift, busy, done}, 5'b0);
            checkOutput("idle_cnt", cnt, 3'd0);
        end

        $display("[TB] multiplier 0000");
        runOp(4'b1101, 4'b0000, 10, 4'b0000, 8'd0, 1'b0);
        $display("[TB] multiplier 1011 x 1101");
        runOp(4'b1101, 4'b1011, 13, 4'b1011, 8'd143, 1'b0);
        $display("[TB] multiplier 1111 x 1111, start raised in DONE");
        runOp(4'b1111, 4'b1111, 14, 4'b1111, 8'd225, 1'b1);

        $display("[TB] start held high");
        a_in = 4'd5;
        b_in = 4'd0;
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(1'b1);
            lg_load[c] = load;
            lg_busy[c] = busy;
            lg_done[c] = done;
        end
        ndone = 0;
        for (int c = 1; c <= 30; c++) if (lg_done[c]) ndone++;
        checkOutput("held_done_count", ndone, 2);
        checkOutput("held_first_load", lg_load[1], 1'b1);
        checkOutput("held_done1", lg_done[10], 1'b1);
        checkOutput("held_idle_gap", {lg_load[11], lg_busy[11], lg_done[11]}, 3'b000);
        checkOutput("held_second_load", lg_load[12], 1'b1);
        checkOutput("held_done2", lg_done[21], 1'b1);
        k = 0;
        start = 1'b0;
        while (!done && k < 20) begin
            applyStimulus(1'b0);
            k++;
        end
        checkOutput("held_third_done", done, 1'b1);
        applyStimulus(1'b0);
        checkOutput("held_back_idle", {load, busy, done}, 3'b000);

        $display("[TB] async reset during ADD of iteration 2");
        a_in = 4'd5;
        b_in = 4'b0100;
        applyStimulus(1'b1);
        k = 0;
        while (!(add_en && cnt == 3'd2) && k < 20) begin
            applyStimulus(1'b0);
            k++;
        end
        checkOutput("reached_add_it2", {add_en, cnt}, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_strobes_low", {load, add_en, shift, busy, done}, 5'b0);
        checkOutput("async_cnt_zero", cnt, 3'd0);
        applyStimulus(1'b0);
        checkOutput("reset_no_done", done, 1'b0);
        applyStimulus(1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        checkOutput("post_reset_idle", {load, busy, done}, 3'b000);
        runOp(4'd5, 4'b0100, 11, 4'b0100, 8'd20, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
